// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: shared types and sequence math for the QECIPHY link-test
// traffic generator (TX) and checker (RX). Both ends call seq_seed/seq_next
// so the regenerated sequence matches the transmitted one bit for bit.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_CHECK = 2'd1,
    CHK_DONE  = 2'd2
  } chk_state_e;

  typedef enum logic {
    SEQ_COUNTER  = 1'b0,
    SEQ_XORSHIFT = 1'b1
  } seq_mode_e;

  // xorshift64 has an all-zero fixed point, so a zero seed is replaced.
  localparam logic [63:0] XS_ZERO_SEED = 64'h1;

  function automatic logic [63:0] seq_seed(seq_mode_e mode, logic [63:0] seed);
    if (mode == SEQ_XORSHIFT && seed == 64'd0) return XS_ZERO_SEED;
    return seed;
  endfunction

  // Sequential xorshift64 (13, 7, 17) or a wrapping +1 counter.
  function automatic logic [63:0] seq_next(seq_mode_e mode, logic [63:0] x);
    logic [63:0] y;
    if (mode == SEQ_XORSHIFT) begin
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
    end else begin
      y = x + 64'd1;
    end
    return y;
  endfunction

endpackage

// File: rtl/qeciphy_rx_checker_if.sv
// qeciphy_rx_checker_if: 64-bit AXI-Stream data channel between the PHY RX
// port (master) and the checker (slave).
//   tdata  : stream word
//   tvalid : master has a word
//   tready : slave accepts this cycle
interface qeciphy_rx_checker_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/qeciphy_rx_checker.sv
// qeciphy_rx_checker: AXI-Stream sink that compares received words against a
// locally regenerated counter/xorshift64 sequence and reports the result.
// Ports:
//   aclk, arstn            clock, async active-low reset
//   start_i                one-cycle pulse, arms a run from IDLE or DONE
//   cfg_mode_i             0 = counter, 1 = xorshift64
//   cfg_seed_i             first expected word
//   cfg_len_i              words to check (0 -> straight to DONE)
//   rx                     stream slave port (tdata/tvalid/tready)
//   busy_o / done_o        in CHECK / in DONE
//   pass_o                 done, no errors, no timeout, no overrun
//   err_cnt_o              mismatching beats, saturating
//   word_cnt_o             accepted beats this run
//   first_err_idx_o/_data_o  index and data of the first mismatch
//   timeout_o / overrun_o  sticky: no beat for TIMEOUT_CYCLES / beat offered in DONE
module qeciphy_rx_checker
  import qeciphy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned BP_PERIOD      = 0,
  parameter int unsigned ERR_W          = 16
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic                   start_i,
  input  logic                   cfg_mode_i,
  input  logic [63:0]            cfg_seed_i,
  input  logic [31:0]            cfg_len_i,
  qeciphy_rx_checker_if.slave    rx,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ERR_W-1:0]       err_cnt_o,
  output logic [31:0]            word_cnt_o,
  output logic [31:0]            first_err_idx_o,
  output logic [63:0]            first_err_data_o,
  output logic                   timeout_o,
  output logic                   overrun_o
);

  localparam int unsigned BP_W = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;
  localparam logic [BP_W-1:0] BP_LAST = (BP_PERIOD == 0) ? '0 : BP_W'(BP_PERIOD - 1);

  chk_state_e        state_q, state_d;
  seq_mode_e         mode_q, mode_d;
  logic [31:0]       len_q, len_d;
  logic [63:0]       exp_q, exp_d;
  logic [31:0]       word_q, word_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [31:0]       fidx_q, fidx_d;
  logic [63:0]       fdata_q, fdata_d;
  logic              to_q, to_d;
  logic              ov_q, ov_d;
  logic [BP_W-1:0]   bp_q, bp_d;
  logic [31:0]       idle_q, idle_d;

  logic              arm;
  logic              bp_stall;
  logic              tready;
  logic              beat;

  // Stall on the last slot of each BP_PERIOD window.
  assign bp_stall = (BP_PERIOD != 0) && (bp_q == BP_LAST);
  assign tready   = (state_q == CHK_CHECK) && !bp_stall;
  assign beat     = rx.tvalid && tready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    exp_d   = exp_q;
    word_d  = word_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
    to_d    = to_q;
    ov_d    = ov_q;
    bp_d    = bp_q;
    idle_d  = idle_q;
    arm     = 1'b0;

    case (state_q)
      CHK_IDLE: begin
        if (start_i) arm = 1'b1;
      end

      CHK_CHECK: begin
        bp_d = (bp_q == BP_LAST) ? '0 : bp_q + 1'b1;
        if (beat) begin
          // Expected value advances on every beat; a bad word does not resync.
          exp_d  = seq_next(mode_q, exp_q);
          word_d = word_q + 32'd1;
          idle_d = '0;
          if (rx.tdata != exp_q) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) begin
              fidx_d  = word_q;
              fdata_d = rx.tdata;
            end
          end
          if (word_q + 32'd1 == len_q) state_d = CHK_DONE;
        end else begin
          idle_d = idle_q + 32'd1;
          if (TIMEOUT_CYCLES != 0 && idle_q + 32'd1 == TIMEOUT_CYCLES) begin
            to_d    = 1'b1;
            state_d = CHK_DONE;
          end
        end
      end

      CHK_DONE: begin
        if (rx.tvalid) ov_d = 1'b1;
        if (start_i)   arm  = 1'b1;
      end

      default: state_d = CHK_IDLE;
    endcase

    // Arming overrides everything else a DONE cycle might have updated.
    if (arm) begin
      mode_d  = seq_mode_e'(cfg_mode_i);
      len_d   = cfg_len_i;
      exp_d   = seq_seed(seq_mode_e'(cfg_mode_i), cfg_seed_i);
      word_d  = '0;
      err_d   = '0;
      fidx_d  = '0;
      fdata_d = '0;
      to_d    = 1'b0;
      ov_d    = 1'b0;
      bp_d    = '0;
      idle_d  = '0;
      state_d = (cfg_len_i == 32'd0) ? CHK_DONE : CHK_CHECK;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= CHK_IDLE;
      mode_q  <= SEQ_COUNTER;
      len_q   <= '0;
      exp_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fdata_q <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
      bp_q    <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      word_q  <= word_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
      bp_q    <= bp_d;
      idle_q  <= idle_d;
    end
  end

  assign rx.tready        = tready;
  assign busy_o           = (state_q == CHK_CHECK);
  assign done_o           = (state_q == CHK_DONE);
  assign pass_o           = done_o && (err_q == '0) && !to_q && !ov_q;
  assign err_cnt_o        = err_q;
  assign word_cnt_o       = word_q;
  assign first_err_idx_o  = fidx_q;
  assign first_err_data_o = fdata_q;
  assign timeout_o        = to_q;
  assign overrun_o        = ov_q;

endmodule
